// File: rtl/ctrl_pipeline_hazard.sv
// ---------------------------------------------------------------------------
// ctrl_pipeline_hazard
//   Carries the decoded control bundles from ID through the ID/EX, EX/MEM
//   and MEM/WB control registers, detects load-use hazards (stall the front
//   end and insert one bubble), resolves BEQ/BNE in MEM (flush the younger
//   instructions) and produces the EX operand-forwarding selects.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   id_EX_control [3:0]        {RegDst, ALUSrc, ALUOp[1:0]} of the ID instruction
//   id_M_control  [3:0]        {MemRead, MemWrite, Branch, BOP} of the ID instruction
//   id_WB_control [1:0]        {RegWrite, MemtoReg} of the ID instruction
//   id_rs/id_rt/id_rd          register fields of the ID instruction
//   ex_zero                    ALU zero flag of the EX instruction
//   ex_EX_control              ID/EX EX bundle
//   mem_M_control              EX/MEM M bundle
//   wb_WB_control              MEM/WB WB bundle
//   ex_dest/mem_dest/wb_dest   destination register per stage
//   forward_a/forward_b        EX operand source: 10 EX/MEM, 01 MEM/WB, 00 regfile
//   pc_write, if_id_write      front-end enables (low during a load-use stall)
//   if_id_flush, pc_src        taken-branch flush and target select
// ---------------------------------------------------------------------------
module ctrl_pipeline_hazard #(
    parameter int unsigned REG_W    = 5,
    parameter logic [9:0]  NOP_CTRL = 10'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_EX_control,
    input  logic [3:0]       id_M_control,
    input  logic [1:0]       id_WB_control,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_zero,
    output logic [3:0]       ex_EX_control,
    output logic [3:0]       mem_M_control,
    output logic [1:0]       wb_WB_control,
    output logic [REG_W-1:0] ex_dest,
    output logic [REG_W-1:0] mem_dest,
    output logic [REG_W-1:0] wb_dest,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             pc_src
);

    // Bubble slices of NOP_CTRL = {EX, M, WB}
    localparam logic [3:0] NOP_EX = NOP_CTRL[9:6];
    localparam logic [3:0] NOP_M  = NOP_CTRL[5:2];
    localparam logic [1:0] NOP_WB = NOP_CTRL[1:0];

    // Bit positions inside the bundles
    localparam int unsigned EX_REGDST   = 3;
    localparam int unsigned M_MEMREAD   = 3;
    localparam int unsigned M_BRANCH    = 1;
    localparam int unsigned M_BOP       = 0;
    localparam int unsigned WB_REGWRITE = 1;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // ID/EX
    logic [3:0]       idex_ex;
    logic [3:0]       idex_m;
    logic [1:0]       idex_wb;
    logic [REG_W-1:0] idex_rs;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] idex_rd;

    // EX/MEM
    logic [3:0]       exmem_m;
    logic [1:0]       exmem_wb;
    logic [REG_W-1:0] exmem_dest;
    logic             mem_zero;

    // MEM/WB
    logic [1:0]       memwb_wb;
    logic [REG_W-1:0] memwb_dest;

    // Combinational hazard / branch terms
    logic [REG_W-1:0] ex_dest_c;
    logic             branch_taken;
    logic             load_use;

    always_comb begin
        ex_dest_c = idex_ex[EX_REGDST] ? idex_rd : idex_rt;
    end

    // BEQ (BOP=1) taken on zero, BNE (BOP=0) taken on non-zero
    always_comb begin
        branch_taken = exmem_m[M_BRANCH] & ~(mem_zero ^ exmem_m[M_BOP]);
    end

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use = idex_m[M_MEMREAD]
                 & (ex_dest_c != '0)
                 & ((ex_dest_c == id_rs) | (ex_dest_c == id_rt));
    end

    // EX/MEM is checked first so the youngest producer wins
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input logic [1:0]       mwb,
                                           input logic [REG_W-1:0] mdest,
                                           input logic [1:0]       wwb,
                                           input logic [REG_W-1:0] wdest);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mwb[WB_REGWRITE] && (mdest != '0) && (mdest == src))
            sel = FWD_EXMEM;
        else if (wwb[WB_REGWRITE] && (wdest != '0) && (wdest == src))
            sel = FWD_MEMWB;
        return sel;
    endfunction

    always_comb begin
        forward_a = fwd_sel(idex_rs, exmem_wb, exmem_dest, memwb_wb, memwb_dest);
        forward_b = fwd_sel(idex_rt, exmem_wb, exmem_dest, memwb_wb, memwb_dest);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_ex    <= '0;
            idex_m     <= '0;
            idex_wb    <= '0;
            idex_rs    <= '0;
            idex_rt    <= '0;
            idex_rd    <= '0;
            exmem_m    <= '0;
            exmem_wb   <= '0;
            exmem_dest <= '0;
            mem_zero   <= 1'b0;
            memwb_wb   <= '0;
            memwb_dest <= '0;
        end else begin
            // A flush and a stall both bubble ID/EX; the register fields are
            // cleared too so a bubble never looks like a forwarding consumer.
            if (branch_taken || load_use) begin
                idex_ex <= NOP_EX;
                idex_m  <= NOP_M;
                idex_wb <= NOP_WB;
                idex_rs <= '0;
                idex_rt <= '0;
                idex_rd <= '0;
            end else begin
                idex_ex <= id_EX_control;
                idex_m  <= id_M_control;
                idex_wb <= id_WB_control;
                idex_rs <= id_rs;
                idex_rt <= id_rt;
                idex_rd <= id_rd;
            end

            // Only a flush kills the EX instruction; a stall lets it advance
            if (branch_taken) begin
                exmem_m  <= NOP_M;
                exmem_wb <= NOP_WB;
            end else begin
                exmem_m  <= idex_m;
                exmem_wb <= idex_wb;
            end
            exmem_dest <= ex_dest_c;
            mem_zero   <= ex_zero;

            memwb_wb   <= exmem_wb;
            memwb_dest <= exmem_dest;
        end
    end

    always_comb begin
        ex_EX_control = idex_ex;
        mem_M_control = exmem_m;
        wb_WB_control = memwb_wb;
        ex_dest       = ex_dest_c;
        mem_dest      = exmem_dest;
        wb_dest       = memwb_dest;
        pc_src        = branch_taken;
        if_id_flush   = branch_taken;
        // Flush overrides the stall: the stalled instruction is discarded anyway
        pc_write      = branch_taken | ~load_use;
        if_id_write   = branch_taken | ~load_use;
    end

endmodule

// File: tb/tb_ctrl_pipeline_hazard.sv
module tb_ctrl_pipeline_hazard;
    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   id_EX_control, id_M_control;
    logic [1:0]   id_WB_control;
    logic [W-1:0] id_rs, id_rt, id_rd;
    logic         ex_zero;
    logic [3:0]   ex_EX_control, mem_M_control;
    logic [1:0]   wb_WB_control;
    logic [W-1:0] ex_dest, mem_dest, wb_dest;
    logic [1:0]   forward_a, forward_b;
    logic         pc_write, if_id_write, if_id_flush, pc_src;

    ctrl_pipeline_hazard #(.REG_W(W), .NOP_CTRL(10'b0)) dut (
        .clk(clk), .reset(reset),
        .id_EX_control(id_EX_control), .id_M_control(id_M_control),
        .id_WB_control(id_WB_control),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_EX_control(ex_EX_control), .mem_M_control(mem_M_control),
        .wb_WB_control(wb_WB_control),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .forward_a(forward_a), .forward_b(forward_b),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .pc_src(pc_src)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: one record per instruction in flight
    typedef struct {
        logic [3:0] exc;
        logic [3:0] mc;
        logic [1:0] wbc;
        logic [4:0] rs, rt, rd;
    } instr_t;

    instr_t     in_ex;
    logic [3:0] mem_mc;
    logic [1:0] mem_wbc;
    logic [4:0] mem_dst;
    logic       mem_z;
    logic [1:0] wb_wbc;
    logic [4:0] wb_dst;
    bit         model_valid = 0;

    function automatic logic [4:0] m_ex_dest();
        return (in_ex.exc[3] == 1'b1) ? in_ex.rd : in_ex.rt;
    endfunction

    function automatic logic m_taken();
        if (mem_mc[1] != 1'b1) return 1'b0;
        if (mem_mc[0] == 1'b1) return mem_z;     // BEQ
        return !mem_z;                           // BNE
    endfunction

    function automatic logic m_stall();
        logic [4:0] d;
        d = m_ex_dest();
        return (in_ex.mc[3] == 1'b1) && (d != 0) && (d == id_rs || d == id_rt);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (r == 0) return 2'd0;
        if (mem_wbc[1] == 1'b1 && mem_dst == r) return 2'd2;
        if (wb_wbc[1] == 1'b1 && wb_dst == r) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] e, input logic [3:0] m,
                         input logic [1:0] w, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic z);
        reset = r; id_EX_control = e; id_M_control = m; id_WB_control = w;
        id_rs = s; id_rt = t; id_rd = d; ex_zero = z;
        #1;
    endtask

    task automatic check_model();
        logic tk, st;
        tk = m_taken();
        st = m_stall();
        chk("ex_EX_control", 8'(ex_EX_control), 8'(in_ex.exc));
        chk("mem_M_control", 8'(mem_M_control), 8'(mem_mc));
        chk("wb_WB_control", 8'(wb_WB_control), 8'(wb_wbc));
        chk("ex_dest",  8'(ex_dest),  8'(m_ex_dest()));
        chk("mem_dest", 8'(mem_dest), 8'(mem_dst));
        chk("wb_dest",  8'(wb_dest),  8'(wb_dst));
        chk("forward_a", 8'(forward_a), 8'(m_fwd(in_ex.rs)));
        chk("forward_b", 8'(forward_b), 8'(m_fwd(in_ex.rt)));
        chk("pc_src",      8'(pc_src),      8'(tk));
        chk("if_id_flush", 8'(if_id_flush), 8'(tk));
        chk("pc_write",    8'(pc_write),    8'(tk || !st));
        chk("if_id_write", 8'(if_id_write), 8'(tk || !st));
    endtask

    task automatic cycle();
        logic tk, st;
        logic [4:0] d;
        if (model_valid) check_model();
        tk = m_taken();
        st = m_stall();
        d  = m_ex_dest();
        if (reset) begin
            in_ex = '{exc:0, mc:0, wbc:0, rs:0, rt:0, rd:0};
            mem_mc = 0; mem_wbc = 0; mem_dst = 0; mem_z = 0;
            wb_wbc = 0; wb_dst = 0;
        end else begin
            wb_wbc  = mem_wbc;
            wb_dst  = mem_dst;
            mem_mc  = tk ? 4'd0 : in_ex.mc;
            mem_wbc = tk ? 2'd0 : in_ex.wbc;
            mem_dst = d;
            mem_z   = ex_zero;
            if (tk || st)
                in_ex = '{exc:0, mc:0, wbc:0, rs:0, rt:0, rd:0};
            else
                in_ex = '{exc:id_EX_control, mc:id_M_control, wbc:id_WB_control,
                          rs:id_rs, rt:id_rt, rd:id_rd};
        end
        @(posedge clk);
        #1;
        model_valid = 1;
        vectors++;
    endtask

    task automatic nop(input logic z);
        drive(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, z);
        cycle();
    endtask

    initial begin
        // Reset held two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            drive(1, 4'($urandom), 4'($urandom), 2'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), 1'($urandom));
            cycle();
        end
        chk("rst_ex", 8'(ex_EX_control), 8'h0);
        chk("rst_wbd", 8'(wb_dest), 8'h0);
        drive(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
        chk("rst_pcw", 8'(pc_write), 8'h1);
        chk("rst_ifw", 8'(if_id_write), 8'h1);
        chk("rst_fwd", 8'({forward_a, forward_b}), 8'h0);
        chk("rst_pcsrc", 8'(pc_src), 8'h0);

        // Propagation of an R-type with rd = 5
        drive(0, 4'b1010, 4'b0000, 2'b11, 1, 2, 5, 0);
        cycle();
        chk("prop_ex", 8'(ex_EX_control), 8'b1010);
        nop(0);
        chk("prop_memdest", 8'(mem_dest), 8'd5);
        nop(0);
        chk("prop_wb", 8'(wb_WB_control), 8'b11);
        chk("prop_wbdest", 8'(wb_dest), 8'd5);
        nop(0); nop(0);

        // Load-use: LW r8, then ADD with rs = 8
        drive(0, 4'b0100, 4'b1000, 2'b10, 2, 8, 0, 0);
        cycle();
        drive(0, 4'b1010, 4'b0000, 2'b10, 8, 9, 10, 0);
        chk("lu_pcw", 8'(pc_write), 8'h0);
        chk("lu_ifw", 8'(if_id_write), 8'h0);
        cycle();
        chk("lu_bubble", 8'(ex_EX_control), 8'h0);
        drive(0, 4'b1010, 4'b0000, 2'b10, 8, 9, 10, 0);
        chk("lu_once", 8'(pc_write), 8'h1);
        cycle();
        chk("lu_fwd_a", 8'(forward_a), 8'b01);
        nop(0); nop(0); nop(0);

        // BEQ taken / not taken, BNE taken
        for (int k = 0; k < 3; k++) begin
            logic [3:0] bm;
            logic       bz, want;
            bm   = (k == 2) ? 4'b0010 : 4'b0011;
            bz   = (k == 0);
            want = (k != 1);
            drive(0, 4'b0000, bm, 2'b00, 1, 2, 0, 0);
            cycle();
            drive(0, 4'b1010, 4'b0100, 2'b10, 3, 4, 6, bz);   // younger instr
            cycle();
            drive(0, 4'b1010, 4'b1000, 2'b11, 5, 6, 7, 0);
            chk("br_pcsrc", 8'(pc_src), 8'(want));
            chk("br_flush", 8'(if_id_flush), 8'(want));
            cycle();
            if (want) begin
                chk("br_idex0", 8'(ex_EX_control), 8'h0);
                chk("br_exmem0", 8'(mem_M_control), 8'h0);
            end
            nop(0); nop(0); nop(0);
        end

        // Forward priority: two writers of r3, then a reader of r3 on both ports
        drive(0, 4'b1010, 4'b0000, 2'b10, 1, 2, 3, 0); cycle();
        drive(0, 4'b1010, 4'b0000, 2'b10, 4, 5, 3, 0); cycle();
        drive(0, 4'b1010, 4'b0000, 2'b10, 3, 3, 6, 0); cycle();
        chk("pri_fa", 8'(forward_a), 8'b10);
        chk("pri_fb", 8'(forward_b), 8'b10);
        nop(0); nop(0); nop(0);

        // Writes to r0 never forward or stall
        drive(0, 4'b1010, 4'b0000, 2'b10, 1, 2, 0, 0); cycle();
        drive(0, 4'b1010, 4'b0000, 2'b10, 0, 0, 6, 0); cycle();
        chk("r0_fa", 8'(forward_a), 8'h0);
        chk("r0_fb", 8'(forward_b), 8'h0);
        drive(0, 4'b0100, 4'b1000, 2'b10, 1, 0, 0, 0); cycle();
        drive(0, 4'b1010, 4'b0000, 2'b10, 0, 0, 6, 0);
        chk("r0_nostall", 8'(pc_write), 8'h1);
        cycle();
        nop(0); nop(0); nop(0);

        // Flush together with stall, then the same with reset asserted
        for (int k = 0; k < 2; k++) begin
            drive(0, 4'b0000, 4'b0011, 2'b00, 1, 2, 0, 0); cycle();
            drive(0, 4'b0100, 4'b1000, 2'b10, 2, 7, 0, 1); cycle();
            drive(logic'(k), 4'b1010, 4'b0000, 2'b10, 7, 1, 9, 0);
            chk("fs_pcw", 8'(pc_write), 8'h1);
            chk("fs_ifw", 8'(if_id_write), 8'h1);
            chk("fs_flush", 8'(if_id_flush), 8'h1);
            cycle();
            chk("fs_idex0", 8'(ex_EX_control), 8'h0);
            chk("fs_exmem0", 8'(mem_M_control), 8'h0);
            if (k == 1) begin
                chk("fs_rst_wb", 8'(wb_WB_control), 8'h0);
                chk("fs_rst_md", 8'(mem_dest), 8'h0);
            end
            nop(0); nop(0); nop(0);
        end

        // Randomised traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom),
                  2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom));
            cycle();
        end
        drive(0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/ctrl_pipeline_hazard.md
Name: ctrl_pipeline_hazard

Overview:
- Receiving end of the decoded control bundles produced in ID: EX_control {RegDst, ALUSrc, ALUOp[1:0]}, M_control {MemRead, MemWrite, Branch, BOP}, WB_control {RegWrite, MemtoReg}.
- Carries the bundles through the ID/EX, EX/MEM and MEM/WB control registers, and hands each stage its slice.
- Detects load-use hazards and stalls the front end.
- Resolves BEQ/BNE in MEM and flushes the younger instructions.
- Generates EX operand-forwarding selects.

Parameters:
- REG_W, 5, register-index width.
- NOP_CTRL, 10'b0, value inserted as a bubble: {EX, M, WB} all zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_EX_control  in  4  EX bundle for the instruction in ID.
- id_M_control  in  4  M bundle for the instruction in ID.
- id_WB_control  in  2  WB bundle for the instruction in ID.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_rd  in  REG_W  rd field of the instruction in ID.
- ex_zero  in  1  ALU zero flag for the instruction in EX.
- ex_EX_control  out  4  registered ID/EX EX bundle.
- mem_M_control  out  4  registered EX/MEM M bundle.
- wb_WB_control  out  2  registered MEM/WB WB bundle.
- ex_dest  out  REG_W  EX destination: id_ex rd if RegDst = 1, else rt.
- mem_dest  out  REG_W  EX/MEM destination.
- wb_dest  out  REG_W  MEM/WB destination.
- forward_a  out  2  source select for EX operand A.
- forward_b  out  2  source select for EX operand B.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID.
- pc_src  out  1  select branch target.

Behaviour:
- Reset: all pipeline registers (bundles, rs/rt/rd, dests, mem_zero) cleared to 0 on the first edge with reset = 1. Resulting outputs: every bundle and dest = 0, forward_a = forward_b = 00, pc_src = 0, if_id_flush = 0, pc_write = 1, if_id_write = 1.
- Reset asserted mid-operation: same as above, discarding all in-flight controls.
- Stages, one cycle each:
  - ID/EX ← {id bundles, id_rs, id_rt, id_rd}.
  - EX/MEM ← {M and WB of ID/EX, ex_dest, ex_zero}.
  - MEM/WB ← {WB of EX/MEM, mem_dest}.
  - Latency from ID to the WB slice: 3 edges.
- Branch resolve (combinational from EX/MEM): pc_src = Branch & ~(mem_zero ^ BOP).
  - BEQ (BOP = 1): taken when zero = 1.
  - BNE (BOP = 0): taken when zero = 0.
- Flush (pc_src = 1):
  - if_id_flush = 1, pc_write = 1.
  - Next edge loads NOP_CTRL into ID/EX and into the EX/MEM control fields.
  - MEM/WB loads normally.
- Load-use stall: ID/EX MemRead = 1, ex_dest != 0, and (ex_dest == id_rs or ex_dest == id_rt).
  - pc_write = 0, if_id_write = 0.
  - Next edge loads NOP_CTRL into ID/EX.
  - EX/MEM and MEM/WB advance.
  - Exactly one bubble per load-use pair.
- Simultaneous flush and stall: flush wins. pc_write = 1, if_id_write = 1, if_id_flush = 1, both bubbles inserted.
- Forwarding (combinational, EX rs/rt vs later stages):
  - forward_a = 10 if EX/MEM RegWrite & mem_dest != 0 & mem_dest == ID/EX rs.
  - Else forward_a = 01 if MEM/WB RegWrite & wb_dest != 0 & wb_dest == ID/EX rs.
  - Else forward_a = 00.
  - forward_b uses the same rule against ID/EX rt.
  - When both stages match, EX/MEM wins (youngest producer).
- Don't-care bundle bits (X from the decoder) are registered as driven. Bubbles are always exact zeros.
- Register 0 is never a hazard or forwarding source.

Test Plan:
- Reset: hold reset 2 cycles with random inputs -> all bundles/dests 0, pc_write = 1, if_id_write = 1, forward = 00, pc_src = 0.
- Propagation: R-type (EX = 1010, M = 0000, WB = 11, rd = 5) in ID at cycle 0 -> ex_EX_control = 1010 after edge 1, mem_dest = 5 after edge 2, wb_WB_control = 11 and wb_dest = 5 after edge 3.
- Load-use: LW to rt = 8 (EX = 0100, M = 1000, WB = 10), then ADD with rs = 8 -> one cycle with pc_write = 0 and if_id_write = 0. Next ID/EX = 0. Then forward_a = 01 when ADD reaches EX.
- Branch: BEQ (M = 0011) with ex_zero = 1 -> pc_src = 1 and if_id_flush = 1 one edge later, then ID/EX and EX/MEM controls 0. Repeat with ex_zero = 0 -> pc_src stays 0. BNE (M = 0010) with ex_zero = 0 -> pc_src = 1.
- Forward priority: ADD r3, then ADD r3, then ADD using rs = 3, rt = 3 -> forward_a = forward_b = 10. Writes to r0 -> forward 00, no stall.
- Flush with stall: LW-use pair in ID/EX while a taken BEQ sits in EX/MEM -> pc_write = 1, if_id_flush = 1, both bubbles inserted. Assert reset in the same cycle -> all state 0 next edge.
